dm_abstract_cmd_ctrl: RTL
=========================

# dm_abstract_cmd_ctrl

Sequencer for abstract-command execution through the debug-memory read/write block. It accepts abstract commands and resume requests from the debug-module register file. It loads the command into the abstract-command buffer and raises the GO or RESUME flag that the hart polls. It then follows the hart's HALTED/GOING/RESUMING/EXCEPTION handshake writes, and reports busy and cmderr back to the abstractcs register.

## Interface
- TimeoutCycles, 1023: maximum cycles spent in WAIT_GOING plus EXEC before the command is aborted.
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cmd_valid_i  in  1  single-cycle abstract-command write strobe
- cmd_i  in  32  abstract command word; cmdtype is [31:24]
- resume_req_i  in  1  single-cycle resume request from dmcontrol
- cmderr_clear_i  in  3  W1C mask for cmderr
- hart_halted_i  in  1  hart halted status from the memory block
- going_ack_i  in  1  pulse: hart wrote GOING
- halted_ack_i  in  1  pulse: hart wrote HALTED (command complete)
- exception_i  in  1  pulse: hart wrote EXCEPTION
- resuming_i  in  1  pulse: hart wrote RESUMING
- abs_cmd_we_o  out  1  one-cycle load strobe into the abstract-command buffer
- go_o  out  1  GO flag bit presented to the hart
- resume_o  out  1  RESUME flag bit presented to the hart
- clear_resumeack_o  out  1  one-cycle pulse clearing resumeack
- busy_o  out  1  abstractcs.busy
- cmderr_o  out  3  abstractcs.cmderr

## Operation
- States: IDLE, LOAD, WAIT_GOING, EXEC, RESUME.
- IDLE + cmd_valid_i, with cmderr_o==0:
  - hart_halted_i==0 → cmderr=4 (haltresume); stay IDLE.
  - cmdtype!=0 → cmderr=2 (notsupported); stay IDLE.
  - Otherwise → LOAD.
- IDLE + cmd_valid_i, with cmderr_o!=0: command ignored, no state change.
- LOAD: abs_cmd_we_o=1 for exactly this cycle. Next state is WAIT_GOING, with go_o set.
- WAIT_GOING: on going_ack_i, clear go_o and go to EXEC.
- EXEC:
  - exception_i → cmderr=3, go to IDLE.
  - halted_ack_i → go to IDLE, cmderr unchanged.
  - If both arrive in the same cycle, exception wins.
- IDLE + resume_req_i (no cmd_valid_i), with hart_halted_i==1: pulse clear_resumeack_o, set resume_o, go to RESUME.
- IDLE + resume_req_i with hart_halted_i==0: ignored.
- RESUME: on resuming_i, clear resume_o and go to IDLE.
- cmd_valid_i and resume_req_i in the same IDLE cycle: the command wins and the resume request is dropped (not queued).
- cmd_valid_i while busy_o=1: if cmderr_o==0, set cmderr=1 (busy). The running command continues unaffected.
- resume_req_i while busy_o=1: ignored.
- cmderr:
  - Set only when its current value is 0; the first error is kept.
  - Cleared bitwise by cmderr_clear_i, which is applied before any same-cycle set.
- going_ack_i, halted_ack_i, exception_i, resuming_i arriving in a state that does not expect them are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- busy_o is registered and equals (state!=IDLE).
- For a command accepted at edge N:
  - LOAD, busy_o=1 and abs_cmd_we_o=1 during cycle N+1.
  - go_o=1 from cycle N+2 until the edge at which going_ack_i is sampled.
- A command completing on halted_ack_i sampled at edge M gives busy_o=0 from cycle M+1.
- For a resume accepted at edge N: clear_resumeack_o and resume_o go high in cycle N+1.
- Error-code updates are visible on cmderr_o the cycle after the triggering edge.
- An asynchronous reset mid-command returns to IDLE immediately, drops go_o/resume_o, and clears cmderr. A half-loaded command is discarded.

## Configuration
- DM_ABSCMD_TIMEOUT_EN defined:
  - Counter width is $clog2(TimeoutCycles+1). It is cleared on LOAD exit and increments each cycle in WAIT_GOING or EXEC.
  - When the count reaches TimeoutCycles: set cmderr=7 (other), clear go_o, go to IDLE.
  - A handshake pulse in that same cycle takes precedence over the timeout.
- DM_ABSCMD_TIMEOUT_EN undefined: no counter is built, the FSM waits indefinitely, and cmderr=7 is never produced.

## Test plan
- Basic command: hart halted, cmd_i=0x0022_1008 at edge 0. Required: abs_cmd_we_o in cycle 1, go_o from cycle 2. Drive going_ack_i at 5 and halted_ack_i at 9. Required: busy_o=0 from cycle 10, cmderr_o=0.
- Exception: same command, then exception_i and halted_ack_i together in EXEC. Required: cmderr_o=3, IDLE. A second cmd_valid_i is then ignored until cmderr_clear_i=3'b111.
- Rejected commands: cmd_i=0x0100_0000 → cmderr=2. Hart not halted → cmderr=4. In both cases abs_cmd_we_o never asserts.
- Busy write: cmd_valid_i during EXEC → cmderr=1. The original command still completes on halted_ack_i.
- Resume: resume_req_i at edge 0 → clear_resumeack_o and resume_o high in cycle 1. resuming_i at 4 → resume_o=0 in cycle 5. With cmd_valid_i and resume_req_i simultaneous, only the command runs.
- Timeout (macro on, TimeoutCycles=8): no going_ack_i → cmderr=7 and go_o=0 after 8 WAIT_GOING cycles. Reset asserted mid-EXEC → all outputs 0 immediately.

Source files
------------

// File: rtl/dm_abstract_cmd_ctrl_if.sv
// dm_abstract_cmd_ctrl_if
// Handshake bundle between the debug-module register file / debug-memory
// block and the abstract-command sequencer.
//   master : register-file and hart-handshake side (drives commands and acks)
//   slave  : the sequencer (drives load strobe, GO/RESUME flags, status)
interface dm_abstract_cmd_ctrl_if;
  logic        cmd_valid_i;
  logic [31:0] cmd_i;
  logic        resume_req_i;
  logic [2:0]  cmderr_clear_i;
  logic        hart_halted_i;
  logic        going_ack_i;
  logic        halted_ack_i;
  logic        exception_i;
  logic        resuming_i;
  logic        abs_cmd_we_o;
  logic        go_o;
  logic        resume_o;
  logic        clear_resumeack_o;
  logic        busy_o;
  logic [2:0]  cmderr_o;

  modport master (
    output cmd_valid_i, cmd_i, resume_req_i, cmderr_clear_i, hart_halted_i,
           going_ack_i, halted_ack_i, exception_i, resuming_i,
    input  abs_cmd_we_o, go_o, resume_o, clear_resumeack_o, busy_o, cmderr_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, resume_req_i, cmderr_clear_i, hart_halted_i,
           going_ack_i, halted_ack_i, exception_i, resuming_i,
    output abs_cmd_we_o, go_o, resume_o, clear_resumeack_o, busy_o, cmderr_o
  );
endinterface

// File: rtl/dm_abstract_cmd_ctrl.sv
// dm_abstract_cmd_ctrl
// Sequences abstract-command execution through the debug-memory block:
// loads the command buffer, raises GO/RESUME for the hart, follows the
// hart's GOING/HALTED/EXCEPTION/RESUMING writes and reports busy/cmderr.
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : command/resume requests, cmderr W1C mask, hart status and
//                  handshake pulses in; load strobe, GO, RESUME,
//                  clear_resumeack, busy and cmderr out
//
// Optional feature: define DM_ABSCMD_TIMEOUT_EN to abort a command that
// spends TimeoutCycles cycles in WAIT_GOING plus EXEC (cmderr=7).
//
// state      | meaning
// IDLE       | no command or resume in flight
// LOAD       | command buffer write strobe
// WAIT_GOING | GO raised, waiting for hart to write GOING
// EXEC       | hart running the program buffer
// RESUME     | RESUME raised, waiting for hart to write RESUMING
module dm_abstract_cmd_ctrl #(
  parameter int unsigned TimeoutCycles = 1023
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dm_abstract_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_GOING, EXEC, RESUME} state_e;

  state_e     state_q, state_d;
  logic [2:0] cmderr_q, cmderr_d, err_set, err_cleared;
  logic       clr_ack_q, clr_ack_d;
  logic       busy_q;
  logic       timeout;
  logic       cmd_supported;
  logic       cmd_unused;

  assign cmd_supported = (bus.cmd_i[31:24] == 8'h00);
  // Only cmdtype is inspected here; the rest goes to the command buffer.
  assign cmd_unused    = ^bus.cmd_i[23:0];

`ifdef DM_ABSCMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_q;
  logic            in_flight;

  assign in_flight = (state_q == WAIT_GOING) || (state_q == EXEC);
  // Fires on the last allowed cycle; >= keeps it asserted in EXEC when a
  // GOING ack pre-empted it on that cycle.
  assign timeout   = in_flight && (cnt_q >= CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == LOAD) begin
      cnt_q <= '0;
    end else if (in_flight && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  localparam int unsigned TimeoutUnused = TimeoutCycles;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    err_set   = 3'd0;
    clr_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A command always shadows a same-cycle resume request.
        if (bus.cmd_valid_i) begin
          if (cmderr_q == 3'd0) begin
            if (!bus.hart_halted_i)  err_set = 3'd4;
            else if (!cmd_supported) err_set = 3'd2;
            else                     state_d = LOAD;
          end
        end else if (bus.resume_req_i && bus.hart_halted_i) begin
          state_d   = RESUME;
          clr_ack_d = 1'b1;
        end
      end
      LOAD: state_d = WAIT_GOING;
      WAIT_GOING: begin
        if (bus.going_ack_i) begin
          state_d = EXEC;
        end else if (timeout) begin
          err_set = 3'd7;
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (bus.exception_i) begin
          err_set = 3'd3;
          state_d = IDLE;
        end else if (bus.halted_ack_i) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_set = 3'd7;
          state_d = IDLE;
        end
      end
      RESUME: if (bus.resuming_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Writes while busy flag "busy" unless the FSM already raised an error.
    if ((state_q != IDLE) && bus.cmd_valid_i && (err_set == 3'd0)) err_set = 3'd1;

    // W1C first, then the first error sticks.
    err_cleared = cmderr_q & ~bus.cmderr_clear_i;
    cmderr_d    = ((err_cleared == 3'd0) && (err_set != 3'd0)) ? err_set : err_cleared;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cmderr_q  <= 3'd0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmderr_q  <= cmderr_d;
      clr_ack_q <= clr_ack_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.abs_cmd_we_o      = (state_q == LOAD);
  assign bus.go_o              = (state_q == WAIT_GOING);
  assign bus.resume_o          = (state_q == RESUME);
  assign bus.clear_resumeack_o = clr_ack_q;
  assign bus.busy_o            = busy_q;
  assign bus.cmderr_o          = cmderr_q;

endmodule
